// File: rtl/decoder.sv
// Instruction decoder: splits opcode/rd/imm and derives write-enable and write-back controls.
// One-cycle registered latency, no backpressure (a new instruction is decoded every cycle).
module decoder (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instruction,
    output logic        MemoryWrite,
    output logic [1:0]  WriteRegFrom,
    output logic [3:0]  RegToWrite,
    output logic [7:0]  Immediate,
    output logic        RegWriteEn
);

    typedef enum logic [1:0] {
        WB_ALU   = 2'b00,
        WB_MEM   = 2'b01,
        WB_IMM   = 2'b10,
        WB_IMMHI = 2'b11
    } wb_sel_t;

    typedef struct packed {
        logic       reg_wr;
        logic       mem_wr;
        wb_sel_t    wb_sel;
        logic [3:0] rd;
        logic [7:0] imm;
    } ctrl_t;

    localparam logic [3:0] OP_NOP    = 4'h0;
    localparam logic [3:0] OP_SHR    = 4'h7;
    localparam logic [3:0] OP_LOAD   = 4'h8;
    localparam logic [3:0] OP_STORE  = 4'h9;
    localparam logic [3:0] OP_MOVI   = 4'hA;
    localparam logic [3:0] OP_VLOAD  = 4'hB;
    localparam logic [3:0] OP_VSTORE = 4'hC;
    localparam logic [3:0] OP_MOVHI  = 4'hF;

    logic [3:0] opcode;
    ctrl_t      ctrl_nxt;
    ctrl_t      ctrl_q;

    assign opcode = instruction[15:12];

    // rd/imm pass through for every opcode; only the control bits depend on opcode.
    always_comb begin
        ctrl_nxt        = '0;
        ctrl_nxt.wb_sel = WB_ALU;
        ctrl_nxt.rd     = instruction[11:8];
        ctrl_nxt.imm    = instruction[7:0];
        case (opcode)
            OP_LOAD, OP_VLOAD: begin
                ctrl_nxt.reg_wr = 1'b1;
                ctrl_nxt.wb_sel = WB_MEM;
            end
            OP_STORE, OP_VSTORE: begin
                ctrl_nxt.mem_wr = 1'b1;
            end
            OP_MOVI: begin
                ctrl_nxt.reg_wr = 1'b1;
                ctrl_nxt.wb_sel = WB_IMM;
            end
            OP_MOVHI: begin
                ctrl_nxt.reg_wr = 1'b1;
                ctrl_nxt.wb_sel = WB_IMMHI;
            end
            default: begin
                // ALU ops write back from the ALU; NOP and reserved 0xD/0xE write nothing.
                if (opcode != OP_NOP && opcode <= OP_SHR) begin
                    ctrl_nxt.reg_wr = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q <= '0;
        end else begin
            ctrl_q <= ctrl_nxt;
        end
    end

    assign RegWriteEn   = ctrl_q.reg_wr;
    assign MemoryWrite  = ctrl_q.mem_wr;
    assign WriteRegFrom = ctrl_q.wb_sel;
    assign RegToWrite   = ctrl_q.rd;
    assign Immediate    = ctrl_q.imm;

endmodule

// File: tb/tb_decoder.sv
// Scoreboard bench for decoder: stimulus queues expected outputs, a monitor pops and compares.
module tb_decoder;

    logic        clk;
    logic        rst;
    logic        clk_en;
    logic [15:0] instruction;
    logic        MemoryWrite;
    logic [1:0]  WriteRegFrom;
    logic [3:0]  RegToWrite;
    logic [7:0]  Immediate;
    logic        RegWriteEn;

    typedef struct {
        logic [15:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    event probe;

    decoder dut (
        .clk         (clk),
        .rst         (rst),
        .instruction (instruction),
        .MemoryWrite (MemoryWrite),
        .WriteRegFrom(WriteRegFrom),
        .RegToWrite  (RegToWrite),
        .Immediate   (Immediate),
        .RegWriteEn  (RegWriteEn)
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    // Expected word layout: {RegWriteEn, MemoryWrite, WriteRegFrom[1:0], RegToWrite[3:0], Immediate[7:0]}
    function automatic logic [15:0] pack(input logic rwe, input logic mw, input logic [1:0] wrf,
                                         input logic [3:0] rd, input logic [7:0] imm);
        return {rwe, mw, wrf, rd, imm};
    endfunction

    task automatic push(input string name, input logic [15:0] e);
        exp_t x;
        x.exp  = e;
        x.name = name;
        sb.push_back(x);
    endtask

    // Apply an instruction, queue its expected decode, and let one rising edge register it.
    task automatic step(input string name, input logic [15:0] ins, input logic [15:0] e);
        instruction = ins;
        push(name, e);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin : monitor
        exp_t        x;
        logic [15:0] act;
        forever begin
            @(posedge clk or posedge rst or probe);
            #1;
            if (sb.size() > 0) begin
                x   = sb.pop_front();
                act = {RegWriteEn, MemoryWrite, WriteRegFrom, RegToWrite, Immediate};
                checks++;
                if (act !== x.exp) begin
                    errors++;
                    $display("FAIL %s: got rwe=%b mw=%b wrf=%b rd=%h imm=%h, want rwe=%b mw=%b wrf=%b rd=%h imm=%h",
                             x.name, act[15], act[14], act[13:12], act[11:8], act[7:0],
                             x.exp[15], x.exp[14], x.exp[13:12], x.exp[11:8], x.exp[7:0]);
                end
                checks++;
                if (RegWriteEn === 1'b1 && MemoryWrite === 1'b1) begin
                    errors++;
                    $display("FAIL %s_exclusive: got rwe=%b mw=%b, want not both 1", x.name, RegWriteEn, MemoryWrite);
                end
            end
        end
    end

    initial begin : stim
        int waited;
        clk         = 1'b0;
        clk_en      = 1'b0;
        rst         = 1'b0;
        instruction = 16'hF39D;

        // Asynchronous reset with no clock running.
        #2;
        push("reset_async", 16'h0000);
        rst = 1'b1;
        #4;
        clk_en = 1'b1;
        step("reset_clocked", 16'hF39D, 16'h0000);

        // First edge after release registers the present instruction.
        rst = 1'b0;
        step("movhi_f39d", 16'hF39D, pack(1'b1, 1'b0, 2'b11, 4'h3, 8'h9D));

        // Input change must not reach outputs before the edge.
        instruction = 16'h5678;
        push("latency_hold", pack(1'b1, 1'b0, 2'b11, 4'h3, 8'h9D));
        -> probe;
        #2;
        push("alu_5678", pack(1'b1, 1'b0, 2'b00, 4'h6, 8'h78));
        @(posedge clk);
        @(negedge clk);

        step("store_9412",  16'h9412, pack(1'b0, 1'b1, 2'b00, 4'h4, 8'h12));
        step("load_8a05",   16'h8A05, pack(1'b1, 1'b0, 2'b01, 4'hA, 8'h05));
        step("rsvd_d7ff",   16'hD7FF, pack(1'b0, 1'b0, 2'b00, 4'h7, 8'hFF));
        step("nop_0000",    16'h0000, pack(1'b0, 1'b0, 2'b00, 4'h0, 8'h00));
        step("add_1fff",    16'h1FFF, pack(1'b1, 1'b0, 2'b00, 4'hF, 8'hFF));
        step("shr_7e01",    16'h7E01, pack(1'b1, 1'b0, 2'b00, 4'hE, 8'h01));
        step("nop_0abc",    16'h0ABC, pack(1'b0, 1'b0, 2'b00, 4'hA, 8'hBC));
        step("vload_bc33",  16'hBC33, pack(1'b1, 1'b0, 2'b01, 4'hC, 8'h33));
        step("vstore_c5aa", 16'hC5AA, pack(1'b0, 1'b1, 2'b00, 4'h5, 8'hAA));
        step("rsvd_e123",   16'hE123, pack(1'b0, 1'b0, 2'b00, 4'h1, 8'h23));
        step("movi_a2c3",   16'hA2C3, pack(1'b1, 1'b0, 2'b10, 4'h2, 8'hC3));

        // Mid-stream reset between edges clears immediately and holds through an edge.
        #1;
        push("reset_mid", 16'h0000);
        rst = 1'b1;
        #2;
        step("reset_hold", 16'h1234, 16'h0000);
        rst = 1'b0;
        step("add_after_rst", 16'h1234, pack(1'b1, 1'b0, 2'b00, 4'h2, 8'h34));
        step("movhi_f000",    16'hF000, pack(1'b1, 1'b0, 2'b11, 4'h0, 8'h00));

        waited = 0;
        while (sb.size() > 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, want 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
